// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side byte handshake shared by NUM_REQ sources
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    modport master (output req_valid, req_data, req_last, input req_ready, grant);
    modport slave  (input req_valid, req_data, req_last, output req_ready, grant);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter with multi-byte lock sharing one uart transmitter
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16,
    parameter int LOCK_IDLE_MAX = 4096
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  req,
    output logic              busy,
    output logic              uart_transmit,
    output logic [7:0]        uart_tx_byte,
    input  logic              uart_is_transmitting,
    output logic              start_err,
    output logic              lock_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(START_TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_IDLE_MAX + 1);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;
    state_t             state, state_nxt;
    logic [IW-1:0]      rr_ptr, owner, win;
    logic               win_ok, lock, xfer, start_to, lock_idle, lock_to;
    logic [SW-1:0]      start_cnt;
    logic [LW-1:0]      idle_cnt;
    logic [NUM_REQ-1:0] grant_q, ready;

    function automatic logic [IW-1:0] wrap(int v);
        return IW'(v % NUM_REQ);
    endfunction

    // Scanning downward leaves the first valid index at or after rr_ptr as winner
    always_comb begin
        win = owner;
        win_ok = lock && req.req_valid[owner];
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (!lock && req.req_valid[wrap(int'(rr_ptr) + i)]) begin
                win = wrap(int'(rr_ptr) + i);
                win_ok = 1'b1;
            end
    end

    assign xfer          = state == IDLE && win_ok;
    assign ready         = (xfer && rst) ? NUM_REQ'(1) << win : '0;
    assign req.req_ready = ready;
    assign req.grant     = grant_q;
    assign start_to      = state == WAIT_START && !uart_is_transmitting && start_cnt == SW'(START_TIMEOUT - 1);
    assign lock_idle     = state == IDLE && lock && !req.req_valid[owner];
    assign lock_to       = lock_idle && idle_cnt == LW'(LOCK_IDLE_MAX - 1);
    assign uart_transmit = state == LAUNCH;
    assign busy          = state != IDLE || lock;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = xfer ? LAUNCH : IDLE;
            LAUNCH:     state_nxt = WAIT_START;
            WAIT_START: state_nxt = uart_is_transmitting ? WAIT_DONE : start_to ? IDLE : WAIT_START;
            WAIT_DONE:  state_nxt = uart_is_transmitting ? WAIT_DONE : IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // start_cnt counts cycles since the transmit pulse, the pulse cycle included
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            owner        <= '0;
            lock         <= 1'b0;
            grant_q      <= '0;
            uart_tx_byte <= 8'h00;
            start_cnt    <= '0;
            idle_cnt     <= '0;
            start_err    <= 1'b0;
            lock_err     <= 1'b0;
        end else begin
            start_err <= start_to;
            lock_err  <= lock_to;
            start_cnt <= xfer ? '0 : (state == LAUNCH || state == WAIT_START) ? start_cnt + 1'b1 : start_cnt;
            idle_cnt  <= (xfer || lock_to) ? '0 : lock_idle ? idle_cnt + 1'b1 : idle_cnt;
            if (xfer) begin
                uart_tx_byte <= req.req_data[8*win +: 8];
                grant_q      <= ready;
                rr_ptr       <= wrap(int'(win) + 1);
                owner        <= win;
                lock         <= !req.req_last[win];
            end else if (lock_to || start_to) begin
                lock    <= 1'b0;
                grant_q <= '0;
            end else if (state == WAIT_DONE && !uart_is_transmitting && !lock) begin
                grant_q <= '0;
            end
        end
    end
endmodule
